// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared state encoding and phase-timer helpers for the SRAM controller.
// Rev 1.0
`default_nettype none

package sram_ctrl_pkg;

  localparam int TIMER_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  // A phase of N cycles loads N-1 so the zero flag rises in its last cycle.
  function automatic logic [TIMER_W-1:0] phase_load(input int cycles);
    return TIMER_W'(cycles - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sram_controller_if.sv
// sram_controller_if: single-beat host request / read response channel.
// Rev 1.0
`default_nettype none

interface sram_controller_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

`default_nettype wire

// File: rtl/sram_phase_timer.sv
// sram_phase_timer: loadable down-counter that parks at zero and flags it.
// Rev 1.0
`default_nettype none

module sram_phase_timer
  import sram_ctrl_pkg::*;
(
  input  wire logic               clk,
  input  wire logic               rst_n,
  input  wire logic               load,
  input  wire logic [TIMER_W-1:0] load_value,
  output logic                    zero
);

  logic [TIMER_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - TIMER_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

`default_nettype wire

// File: rtl/sram_controller.sv
// sram_controller: sequences CS/WE/OE strobes with fixed setup/pulse/hold spacing for an async SRAM.
// Rev 1.0
`default_nettype none

module sram_controller
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W       = 4,
  parameter int DATA_W       = 8,
  parameter int SETUP_CYCLES = 1,
  parameter int PULSE_CYCLES = 2,
  parameter int HOLD_CYCLES  = 1
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  sram_controller_if.slave   host,
  output logic [ADDR_W-1:0]  mem_addr,
  inout  wire  [DATA_W-1:0]  mem_data,
  output logic               mem_cs_n,
  output logic               mem_we_n,
  output logic               mem_oe_n
);

  state_t              state;
  logic                req_ready;
  logic                rsp_valid;
  logic [DATA_W-1:0]   rsp_data;
  logic                write_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                drive_en;
  logic                accept;
  logic                timer_load;
  logic [TIMER_W-1:0]  timer_value;
  logic                timer_zero;

  assign accept         = host.req_valid && req_ready;
  assign host.req_ready = req_ready;
  assign host.rsp_valid = rsp_valid;
  assign host.rsp_data  = rsp_data;
  assign mem_data       = drive_en ? wdata_q : {DATA_W{1'bz}};

  // The timer is reloaded on the same edge the FSM changes phase.
  always_comb begin
    timer_load  = 1'b0;
    timer_value = '0;
    case (state)
      ST_IDLE: begin
        timer_load  = accept;
        timer_value = phase_load(SETUP_CYCLES);
      end
      ST_SETUP: begin
        timer_load  = timer_zero;
        timer_value = phase_load(PULSE_CYCLES);
      end
      ST_ACCESS: begin
        timer_load  = timer_zero;
        timer_value = phase_load(HOLD_CYCLES);
      end
      default: begin
        timer_load  = 1'b0;
        timer_value = '0;
      end
    endcase
  end

  sram_phase_timer u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (timer_load),
    .load_value (timer_value),
    .zero       (timer_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      drive_en  <= 1'b0;
      mem_addr  <= '0;
      mem_cs_n  <= 1'b1;
      mem_we_n  <= 1'b1;
      mem_oe_n  <= 1'b1;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          req_ready <= 1'b1;
          if (accept) begin
            state     <= ST_SETUP;
            req_ready <= 1'b0;
            write_q   <= host.req_write;
            wdata_q   <= host.req_wdata;
            drive_en  <= host.req_write;
            mem_addr  <= host.req_addr;
            mem_cs_n  <= 1'b0;
          end
        end
        ST_SETUP: begin
          if (timer_zero) begin
            state    <= ST_ACCESS;
            mem_we_n <= ~write_q;
            mem_oe_n <= write_q;
          end
        end
        ST_ACCESS: begin
          if (timer_zero) begin
            state    <= ST_HOLD;
            mem_we_n <= 1'b1;
            mem_oe_n <= 1'b1;
            // OE is still low up to this edge, so the bus holds the RAM's read data.
            if (!write_q) begin
              rsp_valid <= 1'b1;
              rsp_data  <= mem_data;
            end
          end
        end
        ST_HOLD: begin
          if (timer_zero) begin
            state     <= ST_IDLE;
            mem_cs_n  <= 1'b1;
            drive_en  <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
